piso_serializer: RTL and testbench

Parallel-in, serial-out shift register that takes words over a valid/ready load interface and emits them one bit per clock, with no gap between back-to-back words. It is the transmit-side counterpart to the team's serial-in, parallel-out shift register: its SO/so_valid stream feeds that block's serial input in loopback and link tests. A one-entry holding register decouples the load handshake from the shifter.

---
 rtl/piso_serializer.sv | 109 ++++++++++
 tb/tb_piso_serializer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a one-entry holding register on the load side.
// Words are emitted one bit per clock; a queued word follows the previous one without a gap.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | shift register empty; SO/so_valid/so_last driven low
// SHIFT | shift register holds unsent bits of the current word
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             SO,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic             head_bit;
    logic [WIDTH-1:0] sr_shifted;
    logic             accept;
    logic             word_end;

    // The head bit leaves the register; the opposite end fills with 0.
    always_comb begin
        head_bit   = 1'b0;
        sr_shifted = '0;
        if (MSB_FIRST) begin
            head_bit   = sr[WIDTH-1];
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        end else begin
            head_bit   = sr[0];
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign load_ready = !hold_valid;
    assign accept     = load_valid && !hold_valid;
    assign word_end   = (cnt == LAST_CNT);
    assign busy       = hold_valid || (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            SO         <= 1'b0;
            so_valid   <= 1'b0;
            so_last    <= 1'b0;
        end else begin
            // Accept only fills an empty hold, so it never collides with a transfer out of it.
            if (accept) begin
                hold       <= din;
                hold_valid <= 1'b1;
            end

            case (state)
                SHIFT: begin
                    SO       <= head_bit;
                    so_valid <= 1'b1;
                    so_last  <= word_end;
                    sr       <= sr_shifted;
                    cnt      <= cnt + CW'(1);
                    if (word_end) begin
                        if (hold_valid) begin
                            sr         <= hold;
                            cnt        <= '0;
                            hold_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    SO       <= 1'b0;
                    so_valid <= 1'b0;
                    so_last  <= 1'b0;
                    if (hold_valid) begin
                        sr         <= hold;
                        cnt        <= '0;
                        hold_valid <= 1'b0;
                        state      <= SHIFT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// compared against a queue-based reference model, a directed table and corner sequences.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] din;

    logic so_m, sv_m, sl_m, rdy_m, busy_m;
    logic so_l, sv_l, sl_l, rdy_l, busy_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m), .din(din),
        .SO(so_m), .so_valid(sv_m), .so_last(sl_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l), .din(din),
        .SO(so_l), .so_valid(sv_l), .so_last(sl_l), .busy(busy_l)
    );

    int vectors    = 0;
    int miscompares = 0;
    int step_no    = 0;

    // Reference model: a pending word plus queues of bits still to be emitted in each order.
    bit           m_hv;
    logic [W-1:0] m_hold;
    bit           qm[$];
    bit           ql[$];
    bit           m_so, m_sol, m_sv, m_sl;

    bit cap[$];
    bit cap_last[$];
    int cap_cyc[$];

    function automatic void model_load(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back(w[W-1-i]);
            ql.push_back(w[i]);
        end
        m_hv = 1'b0;
    endfunction

    function automatic void model_edge(input logic r, input logic lv, input logic [W-1:0] d);
        bit hv_pre;
        if (r) begin
            m_hv = 1'b0;
            qm.delete();
            ql.delete();
            {m_so, m_sol, m_sv, m_sl} = 4'b0000;
            return;
        end
        hv_pre = m_hv;
        if (qm.size() != 0) begin
            m_sv  = 1'b1;
            m_so  = qm.pop_front();
            m_sol = ql.pop_front();
            m_sl  = (qm.size() == 0);
            if (qm.size() == 0 && m_hv) model_load(m_hold);
        end else begin
            {m_so, m_sol, m_sv, m_sl} = 4'b0000;
            if (m_hv) model_load(m_hold);
        end
        if (lv && !hv_pre) begin
            m_hold = d;
            m_hv   = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic lv, input logic [W-1:0] d);
        logic [9:0] act, exp;
        rst = r; load_valid = lv; din = d;
        @(posedge clk);
        model_edge(r, lv, d);
        @(negedge clk);
        step_no++;
        act = {so_m, sv_m, sl_m, rdy_m, busy_m, so_l, sv_l, sl_l, rdy_l, busy_l};
        exp = {m_so, m_sv, m_sl, !m_hv, (m_hv || qm.size() != 0),
               m_sol, m_sv, m_sl, !m_hv, (m_hv || qm.size() != 0)};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL model step %0d: got %b, expected %b (so,sv,sl,rdy,busy x msb/lsb)",
                     step_no, act, exp);
        end
        if (sv_m) begin
            cap.push_back(so_m);
            cap_last.push_back(sl_m);
            cap_cyc.push_back(step_no);
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < 50) begin
            done = rdy_m;
            step(1'b0, 1'b1, w);
            n++;
        end
        if (!done) chk("send timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy_m || sv_m) && n < 40) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
        if (busy_m || sv_m) chk("drain timeout", 0, 1);
    endtask

    task automatic clear_cap();
        cap.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic chk_stream(input string name, input logic [15:0] bits, input int n,
                              input logic [15:0] lasts);
        logic [15:0] got_b, got_l;
        got_b = '0; got_l = '0;
        chk({name, " length"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) begin
            got_b[n-1-i] = cap[i];
            got_l[n-1-i] = cap_last[i];
        end
        chk({name, " bits"}, int'(got_b), int'(bits));
        chk({name, " so_last"}, int'(got_l), int'(lasts));
        if (cap.size() > 0)
            chk({name, " contiguous"}, cap_cyc[cap.size()-1] - cap_cyc[0], cap.size() - 1);
    endtask

    typedef struct {
        logic         r;
        logic         lv;
        logic [W-1:0] d;
        logic         so;
        logic         sol;
        logic         sv;
        logic         sl;
        logic         rdy;
        logic         bsy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int cnt;
        rst = 1'b1; load_valid = 1'b0; din = '0;
        m_hv = 1'b0; m_hold = '0;
        {m_so, m_sol, m_sv, m_sl} = 4'b0000;

        // Single word 1011 after a two-cycle reset; expected outputs after each edge.
        //          r  lv  d       so sol sv sl rdy bsy
        tbl[0] = '{1, 0, 4'b0000, 0, 0, 0, 0, 1, 0};
        tbl[1] = '{1, 0, 4'b0000, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 1, 4'b1011, 0, 0, 0, 0, 0, 1};
        tbl[3] = '{0, 0, 4'b0000, 0, 0, 0, 0, 1, 1};
        tbl[4] = '{0, 0, 4'b0000, 1, 1, 1, 0, 1, 1};
        tbl[5] = '{0, 0, 4'b0000, 0, 1, 1, 0, 1, 1};
        tbl[6] = '{0, 0, 4'b0000, 1, 0, 1, 0, 1, 1};
        tbl[7] = '{0, 0, 4'b0000, 1, 1, 1, 1, 1, 0};
        tbl[8] = '{0, 0, 4'b0000, 0, 0, 0, 0, 1, 0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].lv, tbl[i].d);
            vectors++;
            if ({so_m, so_l, sv_m, sl_m, rdy_m, busy_m} !==
                {tbl[i].so, tbl[i].sol, tbl[i].sv, tbl[i].sl, tbl[i].rdy, tbl[i].bsy}) begin
                miscompares++;
                $display("FAIL table row %0d: got so=%b sol=%b sv=%b sl=%b rdy=%b busy=%b, expected %b %b %b %b %b %b",
                         i, so_m, so_l, sv_m, sl_m, rdy_m, busy_m, tbl[i].so, tbl[i].sol,
                         tbl[i].sv, tbl[i].sl, tbl[i].rdy, tbl[i].bsy);
            end
        end

        // Back-to-back words with load_valid held high.
        clear_cap();
        send(4'b1011);
        send(4'b0110);
        drain();
        chk_stream("back-to-back", 16'b1011_0110, 8, 16'b0001_0001);

        // Backpressure: third word waits for the hold register to empty.
        clear_cap();
        send(4'b0001);
        send(4'b1111);
        send(4'b1010);
        drain();
        chk_stream("backpressure", 16'b0001_1111_1010, 12, 16'b0001_0001_0001);

        // Reset after two bits of a word have been emitted.
        clear_cap();
        send(4'b1011);
        cnt = 0;
        while (cap.size() < 2 && cnt < 20) begin
            step(1'b0, 1'b0, '0);
            cnt++;
        end
        chk("midword bits before reset", cap.size(), 2);
        step(1'b1, 1'b0, '0);
        chk("midword SO", so_m, 0);
        chk("midword so_valid", sv_m, 0);
        chk("midword so_last", sl_m, 0);
        chk("midword busy", busy_m, 0);
        chk("midword load_ready", rdy_m, 1);
        clear_cap();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
        chk("midword no residual bits", cap.size(), 0);

        // Reset wins over a simultaneous load.
        step(1'b1, 1'b1, 4'b1010);
        chk("rstprio load_ready", rdy_m, 1);
        chk("rstprio busy", busy_m, 0);
        clear_cap();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        chk("rstprio no output", cap.size(), 0);
        chk("rstprio busy after", busy_m, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
                 W'($urandom_range(0, (1 << W) - 1)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
